// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Round-robin arbitration, one operation in flight, result held until its owner takes it.
module alu_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [3:0]            req0_op,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [3:0]            req1_op,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic                  req1_ready,
   output logic                  rsp0_valid,
   output logic                  rsp1_valid,
   input  logic                  rsp0_ready,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic [3:0]            alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nxt;
   logic   last1;   // 1: requester 1 was granted most recently
   logic   owner;   // requester whose operation is in flight
   logic   accept;

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      case (state)
         IDLE: begin
            // reset is folded in so ready stays low while reset is held
            req0_ready = reset & req0_valid & (~req1_valid | last1);
            req1_ready = reset & req1_valid & (~req0_valid | ~last1);
            if (req0_ready || req1_ready) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp0_valid = ~owner;
            rsp1_valid = owner;
            if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = req0_ready | req1_ready;
   assign busy   = (state != IDLE);

   // control: state, arbitration pointer, owner
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         last1 <= 1'b1;
         owner <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last1 <= req1_ready;
            owner <= req1_ready;
         end
      end
   end

   // operand latch (accept stage) and result capture (end of EXEC)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_op     <= 4'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         if (accept) begin
            alu_op <= req1_ready ? req1_op : req0_op;
            alu_a  <= req1_ready ? req1_a  : req0_a;
            alu_b  <= req1_ready ? req1_b  : req0_b;
         end
         if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stub, queue-based scoreboard,
// directed scenarios followed by randomized traffic.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_op, req1_op, alu_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result, alu_a, alu_b, alu_result;
   logic        rsp_zero, alu_zero, busy;
   logic [32:0] alu_out;

   always #5 clk = ~clk;

   // {zero, result} of the instruction set's ALU
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = ~(a | b);
         4'd3: r = a + b;
         4'd4: r = a - b;
         4'd5: r = {b[15:0], 16'h0000};
         4'd6: r = b << a[4:0];
         4'd7: r = b >> a[4:0];
         default: r = 32'd0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   assign alu_out    = ref_alu(alu_op, alu_a, alu_b);
   assign alu_result = alu_out[31:0];
   assign alu_zero   = alu_out[32];

   alu_arbiter #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
   );

   typedef struct {
      logic        owner;
      logic [31:0] res;
      logic        zero;
      int unsigned acc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   bit          in_flight = 0;
   bit          last1_m = 1;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_zero", rsp_zero, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
   endtask

   // drive one cycle of inputs, then check arbitration against the model
   task automatic apply(input bit v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit r0, input bit r1);
      bit g0, g1;
      logic [32:0] r;
      exp_t e;
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      rsp0_ready = r0; rsp1_ready = r1;
      #1;
      g0 = 0; g1 = 0;
      if (!in_flight) begin
         if (v0 && v1) begin
            g0 = last1_m;
            g1 = !last1_m;
         end else begin
            g0 = v0;
            g1 = v1;
         end
      end
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      check("busy", busy, in_flight);
      if (g0 || g1) begin
         r = g1 ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
         e.owner = g1; e.res = r[31:0]; e.zero = r[32]; e.acc = cyc;
         exp_q.push_back(e);
         last1_m = g1;
         in_flight = 1;
      end
   endtask

   task automatic step(input bit v0, input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                       input bit v1, input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                       input bit r0, input bit r1);
      @(posedge clk);
      #2;
      apply(v0, o0, a0, b0, v1, o1, a1, b1, r0, r1);
   endtask

   task automatic idle(input bit r0, input bit r1);
      step(0, 4'd0, $urandom, $urandom, 0, 4'd0, $urandom, $urandom, r0, r1);
   endtask

   // monitor: compares the response side with the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      logic [1:0] vexp;
      if (reset === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("idle_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
         end else begin
            e = exp_q[0];
            vexp = (cyc - e.acc >= 2) ? (e.owner ? 2'b10 : 2'b01) : 2'b00;
            check("rsp_valid", {rsp1_valid, rsp0_valid}, vexp);
            if (vexp != 2'b00) begin
               check("rsp_result", rsp_result, e.res);
               check("rsp_zero", rsp_zero, e.zero);
               if (e.owner ? rsp1_ready : rsp0_ready) begin
                  void'(exp_q.pop_front());
                  in_flight = 0;
               end
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      req0_valid = 1; req1_valid = 1; req0_op = 4'd3; req1_op = 4'd4;
      req0_a = 32'h1; req0_b = 32'h2; req1_a = 32'h3; req1_b = 32'h4;
      rsp0_ready = 1; rsp1_ready = 1;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs();

      // release and accept an ADD on the very next edge
      @(posedge clk);
      #1 reset = 1'b1;
      #1 apply(1, 4'd3, 32'd5, 32'd7, 0, 4'd0, 0, 0, 1, 1);
      idle(1, 1);
      idle(1, 1);
      check("add_result", rsp_result, 32'd12);
      check("add_zero", rsp_zero, 0);
      check("add_valid", {rsp1_valid, rsp0_valid}, 2'b01);
      idle(1, 1);

      // both requesters always valid: grants alternate
      repeat (12) step(1, $urandom_range(0, 7), $urandom, $urandom,
                       1, $urandom_range(0, 7), $urandom, $urandom, 1, 1);
      repeat (4) idle(1, 1);

      // req1 SUB held in RESP while req0 waits
      step(0, 4'd0, 0, 0, 1, 4'd4, 32'd9, 32'd9, 1, 0);
      step(1, 4'd1, 32'h55, 32'hAA, 0, 4'd0, 0, 0, 1, 0);
      repeat (5) step(1, 4'd1, 32'h55, 32'hAA, 1, 4'd3, 1, 1, 1, 0);
      check("sub_result", rsp_result, 32'd0);
      check("sub_zero", rsp_zero, 1);
      check("sub_valid", {rsp1_valid, rsp0_valid}, 2'b10);
      step(1, 4'd1, 32'h55, 32'hAA, 0, 4'd0, 0, 0, 1, 1);
      step(1, 4'd1, 32'h55, 32'hAA, 0, 4'd0, 0, 0, 1, 1);
      repeat (4) idle(1, 1);

      // SLL with operands changed during EXEC
      step(1, 4'd6, 32'd4, 32'h0000000F, 0, 4'd0, 0, 0, 1, 1);
      step(0, 4'd3, 32'hFFFF_FFFF, 32'h1234_5678, 0, 4'd0, 0, 0, 1, 1);
      idle(1, 1);
      check("sll_result", rsp_result, 32'h0000_00F0);
      idle(1, 1);

      // undefined opcode
      step(0, 4'd0, 0, 0, 1, 4'hC, 32'hDEAD_BEEF, 32'h1357_9BDF, 1, 1);
      idle(1, 1);
      idle(1, 1);
      check("opc_result", rsp_result, 32'd0);
      check("opc_zero", rsp_zero, 1);
      idle(1, 1);

      // reset during EXEC of a LUI discards it
      step(1, 4'd5, 32'd0, 32'h0000_1234, 0, 4'd0, 0, 0, 1, 1);
      @(posedge clk);
      #2 reset = 1'b0;
      exp_q.delete();
      in_flight = 0;
      last1_m = 1;
      #1 check_reset_outputs();
      @(posedge clk);
      #1 reset = 1'b1;
      #1 apply(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, 1);
      repeat (3) idle(1, 1);
      step(1, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 4'd0, 0, 0, 1, 1);
      repeat (3) idle(1, 1);

      // randomized traffic
      repeat (400) step($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom,
                        $urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom,
                        ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
      repeat (6) idle(1, 1);
      check("drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
